// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// UartTxArbiter -- round-robin arbiter that shares one UART transmitter
// among N_REQ byte producers.
//
// Parameters
//   N_REQ      number of requesters (2..8)
//   TO_CYCLES  clk cycles allowed between tx_start and tx_done (16-bit)
//
// Ports
//   clk        single clock, all logic on its rising edge
//   rst_n      synchronous active-low reset
//   req        per-requester "byte pending"
//   lock       per-requester "keep the grant for the next byte"
//   data       byte of requester i on bits [8i+7:8i]
//   ack        one-cycle pulse, byte of requester i captured (one-hot or zero)
//   tx_start   one-cycle start pulse to the transmitter
//   tx_data    byte to the transmitter, held from tx_start until tx_done
//   tx_done    one-cycle completion pulse from the transmitter
//   busy       high whenever the FSM is not in IDLE
//   grant_id   index of the current or most recently granted requester
//   timeout    one-cycle pulse when the transmitter fails to answer in time
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int N_REQ     = 4,
   parameter int TO_CYCLES = 65535
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   lock,
   input  logic [8*N_REQ-1:0] data,
   output logic [N_REQ-1:0]   ack,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_done,
   output logic               busy,
   output logic [2:0]         grant_id,
   output logic               timeout
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT
   } state_t;

   localparam logic [15:0] COUNT_LAST = 16'(TO_CYCLES - 1);
   localparam logic [2:0]  PTR_RESET  = 3'(N_REQ - 1);
   localparam logic [3:0]  N_WRAP     = 4'(N_REQ);

   state_t           state_q;
   logic [2:0]       ptr_q;
   logic [2:0]       grant_q;
   logic [15:0]      count_q;
   logic [N_REQ-1:0] ack_q;
   logic             tx_start_q;
   logic [7:0]       tx_data_q;
   logic             busy_q;
   logic             timeout_q;

   // Inputs widened to the 8-requester maximum so a 3-bit index always
   // addresses them without width games, whatever N_REQ is.
   logic [7:0]  req_pad;
   logic [7:0]  lock_pad;
   logic [63:0] data_pad;

   assign req_pad  = 8'(req);
   assign lock_pad = 8'(lock);
   assign data_pad = 64'(data);

   // Round-robin search: the first pending requester above the pointer,
   // wrapping modulo N_REQ. The pointer holds the last released requester,
   // so it is examined last and cannot starve anyone else.
   logic [2:0] winner_d;
   logic [3:0] cand_d;
   logic       found_d;

   always_comb begin
      winner_d = '0;
      cand_d   = '0;
      found_d  = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand_d = 4'({1'b0, ptr_q}) + 4'(k);
         if (cand_d >= N_WRAP) begin
            cand_d = cand_d - N_WRAP;
         end
         if (!found_d && req_pad[cand_d[2:0]]) begin
            found_d  = 1'b1;
            winner_d = cand_d[2:0];
         end
      end
   end

   // One-hot ack patterns for a fresh winner and for a locked re-grant.
   logic [7:0] onehot_win_d;
   logic [7:0] onehot_grant_d;

   assign onehot_win_d   = 8'b1 << winner_d;
   assign onehot_grant_d = 8'b1 << grant_q;

   // Main FSM. Every output comes straight from a register; pulse outputs
   // default low each cycle and are raised only on the edge that needs them.
   // A locked requester whose byte completes is served again straight from
   // WAIT, which is what makes a locked burst one cycle tighter than a normal
   // hand-over through IDLE. tx_done wins over an expiring counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ptr_q      <= PTR_RESET;
         grant_q    <= '0;
         count_q    <= '0;
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         timeout_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req != '0) begin
                  tx_data_q <= data_pad[{winner_d, 3'b000} +: 8];
                  grant_q   <= winner_d;
                  ack_q     <= onehot_win_d[N_REQ-1:0];
                  busy_q    <= 1'b1;
                  state_q   <= START;
               end
            end
            START: begin
               tx_start_q <= 1'b1;
               count_q    <= '0;
               state_q    <= WAIT;
            end
            WAIT: begin
               if (tx_done) begin
                  if (lock_pad[grant_q] && req_pad[grant_q]) begin
                     tx_data_q <= data_pad[{grant_q, 3'b000} +: 8];
                     ack_q     <= onehot_grant_d[N_REQ-1:0];
                     state_q   <= START;
                  end else begin
                     ptr_q   <= grant_q;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end else if (count_q == COUNT_LAST) begin
                  timeout_q <= 1'b1;
                  ptr_q     <= grant_q;
                  busy_q    <= 1'b0;
                  state_q   <= IDLE;
               end else begin
                  count_q <= count_q + 16'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ack      = ack_q;
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_q;
   assign grant_id = grant_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// TbUartTxArbiter -- self-checking bench for uart_tx_arbiter (N_REQ=4,
// TO_CYCLES=50). The bench plays the UART transmitter and keeps a
// transaction-level reference: round-robin winner by rotating the request
// vector, expected byte, and the cycle on which each pulse must appear.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int TOC  = 50;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [31:0] data;
   logic [3:0]  ack;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic        busy;
   logic [2:0]  grant_id;
   logic        timeout;

   int checks;
   int errors;

   // Reference model state
   int         mPtr;
   int         mGrant;
   logic [7:0] mData;

   uart_tx_arbiter #(
      .N_REQ     (NREQ),
      .TO_CYCLES (TOC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .lock     (lock),
      .data     (data),
      .ack      (ack),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_done  (tx_done),
      .busy     (busy),
      .grant_id (grant_id),
      .timeout  (timeout)
   );

   // Free-running 100 MHz-style clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run always ends even if something wedges
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock and land 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Round-robin winner computed by rotating the request vector so the
   // requester after the last release sits at bit 0
   function automatic int rrWinner(input logic [3:0] r, input int last);
      logic [7:0] dbl;
      int         s;
      dbl = {r, r};
      s   = (last + 1) % NREQ;
      dbl = dbl >> s;
      for (int i = 0; i < NREQ; i++) begin
         if (dbl[i]) return (s + i) % NREQ;
      end
      return -1;
   endfunction

   task automatic doReset();
      rst_n   = 1'b0;
      req     = 4'b0;
      lock    = 4'b0;
      tx_done = 1'b0;
      tick();
      check("rst_ack",     32'(ack),      32'(0));
      check("rst_start",   32'(tx_start), 32'(0));
      check("rst_txdata",  32'(tx_data),  32'(0));
      check("rst_busy",    32'(busy),     32'(0));
      check("rst_grant",   32'(grant_id), 32'(0));
      check("rst_timeout", 32'(timeout),  32'(0));
      rst_n  = 1'b1;
      mPtr   = NREQ - 1;
      mGrant = 0;
      mData  = 8'h00;
   endtask

   // One IDLE cycle with the currently driven req/lock/data
   task automatic applyStimulus(output bit granted);
      int w;
      w = rrWinner(req, mPtr);
      tick();
      check("arb_timeout", 32'(timeout),  32'(0));
      check("arb_start",   32'(tx_start), 32'(0));
      if (w < 0) begin
         granted = 1'b0;
         check("idle_ack",    32'(ack),      32'(0));
         check("idle_busy",   32'(busy),     32'(0));
         check("idle_grant",  32'(grant_id), 32'(mGrant));
         check("idle_txdata", 32'(tx_data),  32'(mData));
      end else begin
         granted = 1'b1;
         mGrant  = w;
         mData   = data[w*8 +: 8];
         check("arb_ack",   32'(ack),      32'(1 << w));
         check("arb_grant", 32'(grant_id), 32'(w));
         check("arb_busy",  32'(busy),     32'(1));
      end
   endtask

   // START cycle plus WAIT until tx_done (on wait cycle doneAt) or timeout.
   // Inputs at the tx_done cycle decide whether a locked re-grant follows.
   task automatic checkOutput(input int doneAt, input bit scramble, input bit doneInStart,
                              input logic [3:0] reqDone, input logic [3:0] lockDone,
                              input logic [31:0] dataDone, output bit regrant);
      tx_done = doneInStart;
      tick();
      tx_done = 1'b0;
      check("start_pulse",  32'(tx_start), 32'(1));
      check("start_txdata", 32'(tx_data),  32'(mData));
      check("start_ack",    32'(ack),      32'(0));
      check("start_busy",   32'(busy),     32'(1));
      regrant = 1'b0;
      for (int k = 1; k <= TOC; k++) begin
         if (k == doneAt) begin
            req     = reqDone;
            lock    = lockDone;
            data    = dataDone;
            tx_done = 1'b1;
         end else if (scramble) begin
            req  = 4'($urandom);
            lock = 4'($urandom);
            data = $urandom;
         end
         tick();
         tx_done = 1'b0;
         if (k == doneAt) begin
            check("done_timeout", 32'(timeout),  32'(0));
            check("done_start",   32'(tx_start), 32'(0));
            check("done_grant",   32'(grant_id), 32'(mGrant));
            if (lockDone[mGrant] && reqDone[mGrant]) begin
               regrant = 1'b1;
               mData   = dataDone[mGrant*8 +: 8];
               check("regrant_ack",  32'(ack),  32'(1 << mGrant));
               check("regrant_busy", 32'(busy), 32'(1));
            end else begin
               mPtr = mGrant;
               check("release_ack",  32'(ack),  32'(0));
               check("release_busy", 32'(busy), 32'(0));
            end
            break;
         end else if (k == TOC) begin
            mPtr = mGrant;
            check("expire_timeout", 32'(timeout), 32'(1));
            check("expire_busy",    32'(busy),    32'(0));
            check("expire_ack",     32'(ack),     32'(0));
         end else begin
            check("wait_flags", 32'({tx_start, timeout, busy, ack, tx_data}),
                  32'({3'b001, 4'b0000, mData}));
         end
      end
   endtask

   initial begin
      bit   g;
      bit   rg;
      int   bursts;
      int   order [5];
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      req     = 4'b0;
      lock    = 4'b0;
      data    = 32'h0;
      tx_done = 1'b0;
      order   = '{0, 1, 2, 3, 0};

      tick();
      doReset();

      // Idle with nothing pending, stray tx_done must be ignored
      tx_done = 1'b1;
      applyStimulus(g);
      tx_done = 1'b0;

      // Single request from requester 2, completion 20 cycles after start
      req  = 4'b0100;
      data = 32'h00A5_0000;
      applyStimulus(g);
      check("single_grant", 32'(grant_id), 32'(2));
      checkOutput(20, 1'b0, 1'b1, 4'b0100, 4'b0000, 32'h00A5_0000, rg);
      check("single_busy_after", 32'(busy), 32'(0));

      // Round robin with all four pending and no lock
      doReset();
      req  = 4'b1111;
      lock = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         data = $urandom;
         applyStimulus(g);
         check("rr_order", 32'(grant_id), 32'(order[i]));
         checkOutput(int'($urandom_range(1, 10)), 1'b0, 1'b0, 4'b1111, 4'b0000, data, rg);
      end

      // Locked burst by requester 1 while requester 0 also waits
      req  = 4'b0011;
      lock = 4'b0010;
      data = 32'h0000_11C0;
      applyStimulus(g);
      check("burst_first_grant", 32'(grant_id), 32'(1));
      checkOutput(3, 1'b0, 1'b0, 4'b0011, 4'b0010, 32'h0000_22C0, rg);
      checkOutput(5, 1'b0, 1'b0, 4'b0011, 4'b0010, 32'h0000_33C0, rg);
      check("burst_third_byte", 32'(tx_data), 32'h0000_0033);
      checkOutput(4, 1'b0, 1'b0, 4'b0011, 4'b0000, 32'h0000_33C0, rg);
      applyStimulus(g);
      check("burst_then_req0", 32'(grant_id), 32'(0));
      checkOutput(2, 1'b0, 1'b0, 4'b0000, 4'b0000, data, rg);

      // Timeout with no tx_done, then tx_done exactly on the expiry cycle
      req  = 4'b0001;
      lock = 4'b0000;
      data = 32'h0000_005A;
      applyStimulus(g);
      checkOutput(1000, 1'b0, 1'b0, 4'b0001, 4'b0000, data, rg);
      applyStimulus(g);
      checkOutput(TOC, 1'b0, 1'b0, 4'b0000, 4'b0000, data, rg);
      tick();
      check("no_late_timeout", 32'(timeout), 32'(0));

      // Reset in the middle of WAIT, then a late tx_done
      req  = 4'b0100;
      data = 32'h0077_0000;
      applyStimulus(g);
      tick();
      check("midreset_start", 32'(tx_start), 32'(1));
      repeat (5) tick();
      doReset();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("late_done_busy",  32'(busy),     32'(0));
      check("late_done_start", 32'(tx_start), 32'(0));
      req  = 4'b1111;
      data = $urandom;
      applyStimulus(g);
      check("post_reset_grant", 32'(grant_id), 32'(0));
      checkOutput(3, 1'b0, 1'b0, 4'b0000, 4'b0000, data, rg);

      // Randomized traffic against the reference model
      repeat (40) begin
         req  = 4'($urandom);
         lock = 4'($urandom);
         data = $urandom;
         applyStimulus(g);
         if (g) begin
            bursts = 0;
            do begin
               checkOutput(int'($urandom_range(1, 55)), 1'b1, 1'($urandom_range(0, 1)),
                           4'($urandom), (bursts < 6) ? 4'($urandom) : 4'b0000,
                           $urandom, rg);
               bursts++;
            end while (rg);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
